// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and a width helper.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_NOR  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ITER,
        ST_DONE
    } state_t;

    // Number of bits needed to index a power-of-two width.
    function automatic int log2_width(input int w);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < w) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one step per cycle.
module seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_step,
    output logic             o_last,
    output logic             o_div_zero,
    output logic [WIDTH-1:0] o_lo_next,
    output logic [WIDTH-1:0] o_hi_next
);
    localparam int CW = log2_width(WIDTH);

    logic               r_div;
    logic               r_div_zero;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic [CW-1:0]      r_cnt;

    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH:0]   w_sh;
    logic [WIDTH:0]     w_top;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_acc_next;

    // Multiply: acc = {partial high, multiplier}; add on LSB then shift right.
    assign w_sum  = r_acc[0] ? ({1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b})
                             : {1'b0, r_acc[2*WIDTH-1:WIDTH]};
    // Divide: acc = {remainder, dividend/quotient}; shift left, trial subtract.
    assign w_sh   = {r_acc, 1'b0};
    assign w_top  = w_sh[2*WIDTH:WIDTH];
    assign w_ge   = (w_top >= {1'b0, r_b});
    assign w_diff = w_top[WIDTH-1:0] - r_b;

    always_comb begin
        w_acc_next = r_acc;
        if (r_div) begin
            if (w_ge) w_acc_next = {w_diff, w_sh[WIDTH-1:1], 1'b1};
            else      w_acc_next = w_sh[2*WIDTH-1:0];
        end else begin
            w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_div      <= 1'b0;
            r_div_zero <= 1'b0;
            r_acc      <= '0;
            r_b        <= '0;
            r_cnt      <= '0;
        end else if (i_start) begin
            r_div      <= i_div;
            r_div_zero <= i_div && (i_b == '0);
            r_acc      <= {{WIDTH{1'b0}}, i_a};
            r_b        <= i_b;
            r_cnt      <= '0;
        end else if (i_step) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_last     = (r_cnt == CW'(WIDTH - 1));
    assign o_div_zero = r_div_zero;
    assign o_lo_next  = w_acc_next[WIDTH-1:0];
    assign o_hi_next  = w_acc_next[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative MULU/DIVU,
// with a start/done handshake and fully registered results.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [3:0]       alu_operation_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] alu_data_o,
    output logic [WIDTH-1:0] hi_data_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             div_zero_o
);
    localparam int SHW = log2_width(WIDTH);

    state_t           r_state;
    logic             r_done;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_zero;
    logic             r_ovf;
    logic             r_dz;

    logic             w_iter_op;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_defined;
    logic             w_last;
    logic             w_md_dz;
    logic [WIDTH-1:0] w_md_lo;
    logic [WIDTH-1:0] w_md_hi;

    assign w_iter_op = (alu_operation_i == OP_MULU) || (alu_operation_i == OP_DIVU);
    assign w_sum     = a_i + b_i;
    assign w_diff    = a_i - b_i;
    assign w_shamt   = b_i[SHW-1:0];

    always_comb begin
        w_res     = '0;
        w_ovf     = 1'b0;
        w_defined = 1'b1;
        case (alu_operation_i)
            OP_AND: w_res = a_i & b_i;
            OP_NOR: w_res = ~(a_i | b_i);
            OP_OR:  w_res = a_i | b_i;
            OP_ADD: begin
                w_res = w_sum;
                w_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (w_sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff;
                w_ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (w_diff[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_SLL: w_res = a_i << w_shamt;
            OP_SRL: w_res = a_i >> w_shamt;
            default: w_defined = 1'b0;
        endcase
    end

    seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk        (clk),
        .reset      (reset),
        .i_start    (start_i && (r_state != ST_ITER) && w_iter_op),
        .i_div      (alu_operation_i == OP_DIVU),
        .i_a        (a_i),
        .i_b        (b_i),
        .i_step     (r_state == ST_ITER),
        .o_last     (w_last),
        .o_div_zero (w_md_dz),
        .o_lo_next  (w_md_lo),
        .o_hi_next  (w_md_hi)
    );

    // zero is registered with the result so every output reads 0 out of reset;
    // undefined opcodes clear all flags, including zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        if (w_iter_op) begin
                            r_state <= ST_ITER;
                        end else begin
                            r_lo    <= w_res;
                            r_hi    <= '0;
                            r_zero  <= w_defined && (w_res == '0);
                            r_ovf   <= w_ovf;
                            r_dz    <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ITER: begin
                    if (w_last) begin
                        r_lo    <= w_md_lo;
                        r_hi    <= w_md_hi;
                        r_zero  <= (w_md_lo == '0);
                        r_ovf   <= 1'b0;
                        r_dz    <= w_md_dz;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o     = (r_state == ST_ITER);
    assign done_o     = r_done;
    assign alu_data_o = r_lo;
    assign hi_data_o  = r_hi;
    assign zero_o     = r_zero;
    assign overflow_o = r_ovf;
    assign div_zero_o = r_dz;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: a 32-bit and an 8-bit instance share clock and reset.
module tb_seq_alu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        s32, busy32, done32, zero32, ovf32, dz32;
    logic [3:0]  op32;
    logic [31:0] a32, b32, lo32, hi32;

    logic        s8, busy8, done8, zero8, ovf8, dz8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8, lo8, hi8;

    int n_cmp = 0;
    int n_fail = 0;

    seq_alu #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(rst_n), .start_i(s32), .alu_operation_i(op32),
        .a_i(a32), .b_i(b32), .busy_o(busy32), .done_o(done32),
        .alu_data_o(lo32), .hi_data_o(hi32), .zero_o(zero32),
        .overflow_o(ovf32), .div_zero_o(dz32)
    );

    seq_alu #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(rst_n), .start_i(s8), .alu_operation_i(op8),
        .a_i(a8), .b_i(b8), .busy_o(busy8), .done_o(done8),
        .alu_data_o(lo8), .hi_data_o(hi8), .zero_o(zero8),
        .overflow_o(ovf8), .div_zero_o(dz8)
    );

    typedef struct {
        bit          narrow;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_lo;
        logic        exp_zero;
        logic        exp_ovf;
        string       name;
    } vec_t;

    vec_t vecs[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit narrow, input logic s, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (narrow) begin
            s8 = s; op8 = op; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            s32 = s; op32 = op; a32 = a; b32 = b;
        end
    endtask

    // Issue one single-cycle op and check the result in the following cycle.
    task automatic apply(input vec_t v);
        drive(v.narrow, 1'b1, v.op, v.a, v.b);
        tick();
        drive(v.narrow, 1'b0, 4'b0000, 32'h0, 32'h0);
        if (v.narrow) begin
            check({v.name, "_done"}, 32'(done8), 32'h1);
            check({v.name, "_lo"},   32'(lo8),   32'(v.exp_lo[7:0]));
            check({v.name, "_hi"},   32'(hi8),   32'h0);
            check({v.name, "_zero"}, 32'(zero8), 32'(v.exp_zero));
            check({v.name, "_ovf"},  32'(ovf8),  32'(v.exp_ovf));
            check({v.name, "_busy"}, 32'(busy8), 32'h0);
        end else begin
            check({v.name, "_done"}, 32'(done32), 32'h1);
            check({v.name, "_lo"},   lo32,        v.exp_lo);
            check({v.name, "_hi"},   hi32,        32'h0);
            check({v.name, "_zero"}, 32'(zero32), 32'(v.exp_zero));
            check({v.name, "_ovf"},  32'(ovf32),  32'(v.exp_ovf));
            check({v.name, "_dz"},   32'(dz32),   32'h0);
        end
        tick();
        check({v.name, "_pulse"}, 32'(v.narrow ? done8 : done32), 32'h0);
    endtask

    // Issue an iterative op; lat counts cycles from the start edge to done.
    task automatic run_iter(input bit narrow, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, output int lat, output int busy_cnt);
        drive(narrow, 1'b1, op, a, b);
        tick();
        drive(narrow, 1'b0, 4'b0000, 32'h0, 32'h0);
        lat = 1;
        busy_cnt = 0;
        while (!(narrow ? done8 : done32) && lat < 100) begin
            if (narrow ? busy8 : busy32) busy_cnt++;
            tick();
            lat++;
        end
        check("iter_busy_at_done", 32'(narrow ? busy8 : busy32), 32'h0);
    endtask

    initial begin
        int lat, bc;
        bit seen;

        vecs[0]  = '{0, 4'b0011, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, "add_ovf"};
        vecs[1]  = '{0, 4'b0100, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, "sub_zero"};
        vecs[2]  = '{0, 4'b0010, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0, 1'b0, "or"};
        vecs[3]  = '{0, 4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, "and"};
        vecs[4]  = '{0, 4'b0001, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, "nor"};
        vecs[5]  = '{0, 4'b0100, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, "sub_ovf"};
        vecs[6]  = '{0, 4'b0011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, "add_wrap"};
        vecs[7]  = '{0, 4'b0101, 32'h00000005, 32'h00000003, 32'h00000000, 1'b1, 1'b0, "slt_false"};
        vecs[8]  = '{0, 4'b0101, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, "slt_neg"};
        vecs[9]  = '{0, 4'b0110, 32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1'b0, "sll32_mask"};
        vecs[10] = '{0, 4'b0100, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0, "sub_neg"};
        vecs[11] = '{1, 4'b0110, 32'h00000081, 32'h00000001, 32'h00000002, 1'b0, 1'b0, "sll8"};
        vecs[12] = '{1, 4'b0111, 32'h00000081, 32'h00000009, 32'h00000040, 1'b0, 1'b0, "srl8_mask"};
        vecs[13] = '{1, 4'b0101, 32'h000000FF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, "slt8"};
        vecs[14] = '{1, 4'b1111, 32'h000000AA, 32'h00000055, 32'h00000000, 1'b0, 1'b0, "undef8"};
        vecs[15] = '{1, 4'b0011, 32'h0000007F, 32'h00000001, 32'h00000080, 1'b0, 1'b1, "add8_ovf"};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 4'b0000, 32'h0, 32'h0);
        repeat (3) tick();
        check("rst_lo",   lo32, 32'h0);
        check("rst_hi",   hi32, 32'h0);
        check("rst_flags", {27'h0, busy32, done32, zero32, ovf32, dz32}, 32'h0);
        check("rst8_all", {11'h0, busy8, done8, zero8, ovf8, dz8, lo8, hi8}, 32'h0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) apply(vecs[i]);

        // Back-to-back: second start issued in the DONE cycle of the first.
        drive(1'b0, 1'b1, 4'b0100, 32'h5, 32'h5);
        tick();
        check("b2b_sub_done", 32'(done32), 32'h1);
        check("b2b_sub_zero", 32'(zero32), 32'h1);
        drive(1'b0, 1'b1, 4'b0010, 32'hF0, 32'h0F);
        tick();
        drive(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        check("b2b_or_done", 32'(done32), 32'h1);
        check("b2b_or_lo",   lo32, 32'hFF);
        check("b2b_or_zero", 32'(zero32), 32'h0);
        tick();

        run_iter(1'b0, 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
        check("mulu_lat",  32'(lat), 32'd33);
        check("mulu_busy", 32'(bc),  32'd32);
        check("mulu_hi",   hi32, 32'hFFFFFFFE);
        check("mulu_lo",   lo32, 32'h00000001);
        check("mulu_ovf",  32'(ovf32), 32'h0);
        tick();
        check("mulu_pulse", 32'(done32), 32'h0);

        run_iter(1'b0, 4'b1000, 32'h00010000, 32'h00010000, lat, bc);
        check("mulu2_hi",   hi32, 32'h00000001);
        check("mulu2_lo",   lo32, 32'h00000000);
        check("mulu2_zero", 32'(zero32), 32'h1);

        run_iter(1'b0, 4'b1001, 32'd100, 32'd7, lat, bc);
        check("divu_q",   lo32, 32'd14);
        check("divu_r",   hi32, 32'd2);
        check("divu_dz",  32'(dz32), 32'h0);
        check("divu_lat", 32'(lat), 32'd33);

        run_iter(1'b0, 4'b1001, 32'd9, 32'd0, lat, bc);
        check("div0_q",   lo32, 32'hFFFFFFFF);
        check("div0_r",   hi32, 32'd9);
        check("div0_dz",  32'(dz32), 32'h1);
        check("div0_lat", 32'(lat), 32'd33);

        // A single-cycle op after div-by-zero clears the flag.
        apply('{0, 4'b0010, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0, "or_after_div0"});

        run_iter(1'b1, 4'b1000, 32'hFF, 32'hFF, lat, bc);
        check("mulu8_hi",  32'(hi8), 32'hFE);
        check("mulu8_lo",  32'(lo8), 32'h01);
        check("mulu8_lat", 32'(lat), 32'd9);
        check("mulu8_busy", 32'(bc), 32'd8);

        run_iter(1'b1, 4'b1001, 32'd200, 32'd13, lat, bc);
        check("divu8_q", 32'(lo8), 32'd15);
        check("divu8_r", 32'(hi8), 32'd5);

        // start_i pulsed during ITER must not disturb the running divide.
        drive(1'b0, 1'b1, 4'b1001, 32'd100, 32'd7);
        tick();
        drive(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        repeat (4) tick();
        drive(1'b0, 1'b1, 4'b0011, 32'h1, 32'h1);
        repeat (3) tick();
        drive(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        lat = 8;
        while (!done32 && lat < 100) begin
            tick();
            lat++;
        end
        check("ign_lat", 32'(lat), 32'd33);
        check("ign_q",   lo32, 32'd14);
        check("ign_r",   hi32, 32'd2);
        tick();
        check("ign_no_extra_done", 32'(done32), 32'h0);

        // Reset in the 10th busy cycle of a MULU abandons it.
        drive(1'b0, 1'b1, 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF);
        tick();
        drive(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        repeat (9) tick();
        check("rmid_busy_before", 32'(busy32), 32'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rmid_lo",    lo32, 32'h0);
        check("rmid_hi",    hi32, 32'h0);
        check("rmid_flags", {27'h0, busy32, done32, zero32, ovf32, dz32}, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done32 || busy32) seen = 1'b1;
            tick();
        end
        check("rmid_no_done", 32'(seen), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
